// File: rtl/dma_utils_pkg.sv
// Shared DMA types: descriptor and burst-command payloads, scheduler states, sizing constants.
package dma_utils_pkg;

  localparam int unsigned AXI_DATA_WIDTH  = 32;
  localparam int unsigned DMA_ADDR_WIDTH  = 32;
  localparam int unsigned DMA_LEN_WIDTH   = 24;
  localparam int unsigned DMA_BEATS_WIDTH = DMA_LEN_WIDTH + 1;
  localparam int unsigned DMA_NUM_DESC    = 4;
  localparam int unsigned DMA_4K_BOUNDARY = 4096;

  typedef struct packed {
    logic [DMA_ADDR_WIDTH-1:0] src_addr;
    logic [DMA_ADDR_WIDTH-1:0] dst_addr;
    logic [DMA_LEN_WIDTH-1:0]  num_bytes;
    logic                      rd_mode;
    logic                      wr_mode;
    logic                      enable;
  } s_dma_desc_t;

  typedef struct packed {
    logic [DMA_ADDR_WIDTH-1:0] src;
    logic [DMA_ADDR_WIDTH-1:0] dst;
    logic [7:0]                alen;
    logic                      rd_fixed;
    logic                      wr_fixed;
    logic                      last;
  } s_dma_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } dma_sched_st_t;

endpackage

// File: rtl/dma_burst_calc.sv
// Combinational burst sizer: min(beats_rem, max_burst+1, 4 KB room per incrementing side, 16 if any side fixed).
module dma_burst_calc
  import dma_utils_pkg::*;
#(
  parameter int unsigned BYTES_PER_BEAT = AXI_DATA_WIDTH / 8
) (
  input  logic [11:0]                src_off,
  input  logic [11:0]                dst_off,
  input  logic [DMA_BEATS_WIDTH-1:0] beats_rem,
  input  logic [7:0]                 max_burst,
  input  logic                       rd_fixed,
  input  logic                       wr_fixed,
  output logic [8:0]                 beats_c
);

  localparam int unsigned SHIFT = $clog2(BYTES_PER_BEAT);

  logic [12:0] src_room;
  logic [12:0] dst_room;
  logic [8:0]  lim;

  assign src_room = (13'(DMA_4K_BOUNDARY) - {1'b0, src_off}) >> SHIFT;
  assign dst_room = (13'(DMA_4K_BOUNDARY) - {1'b0, dst_off}) >> SHIFT;

  // Successively clamp the AXI length limit by every applicable constraint.
  always_comb begin
    lim = 9'(max_burst) + 9'd1;
    if (!rd_fixed && (13'(lim) > src_room)) lim = src_room[8:0];
    if (!wr_fixed && (13'(lim) > dst_room)) lim = dst_room[8:0];
    if ((rd_fixed || wr_fixed) && (lim > 9'd16)) lim = 9'd16;
    if (DMA_BEATS_WIDTH'(lim) > beats_rem) lim = beats_rem[8:0];
    beats_c = lim;
  end

endmodule

// File: rtl/dma_desc_sched.sv
// Descriptor scheduler: walks enabled descriptors, splits them into AXI-legal bursts, tracks outstanding.
module dma_desc_sched
  import dma_utils_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned BYTES_PER_BEAT  = AXI_DATA_WIDTH / 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      dma_go_i,
  input  logic                      dma_abort_i,
  input  logic [7:0]                dma_max_burst_i,
  input  s_dma_desc_t               dma_desc_i [DMA_NUM_DESC],
  output logic                      cmd_valid_o,
  input  logic                      cmd_ready_i,
  output logic [DMA_ADDR_WIDTH-1:0] cmd_src_o,
  output logic [DMA_ADDR_WIDTH-1:0] cmd_dst_o,
  output logic [7:0]                cmd_alen_o,
  output logic                      cmd_rd_fixed_o,
  output logic                      cmd_wr_fixed_o,
  output logic                      cmd_last_o,
  input  logic                      cmp_valid_i,
  input  logic                      cmp_err_i,
  output logic                      dma_done_o,
  output logic                      dma_error_o,
  output logic                      dma_active_o
);

  localparam int unsigned SHIFT = $clog2(BYTES_PER_BEAT);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned IDX_W = $clog2(DMA_NUM_DESC);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned AW    = DMA_ADDR_WIDTH;
  localparam int unsigned BW    = DMA_BEATS_WIDTH;
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(BYTES_PER_BEAT - 1);

  dma_sched_st_t state;
  logic             go_q;
  logic [CNT_W-1:0] idx;
  logic [AW-1:0]    cur_src;
  logic [AW-1:0]    cur_dst;
  logic [BW-1:0]    beats_rem;
  logic             rd_fix;
  logic             wr_fix;
  logic [OUT_W-1:0] outst;
  logic             abort_req;
  s_dma_cmd_t       cmd_q;

  s_dma_desc_t      cand;
  logic             cand_ok;
  logic             idx_end;
  logic [BW-1:0]    cand_beats;
  logic             is_load;
  logic [AW-1:0]    calc_src;
  logic [AW-1:0]    calc_dst;
  logic [BW-1:0]    calc_rem;
  logic             calc_rdf;
  logic             calc_wrf;
  logic [8:0]       beats;
  logic [AW-1:0]    step;
  logic [AW-1:0]    nxt_src;
  logic [AW-1:0]    nxt_dst;
  logic [BW-1:0]    nxt_rem;
  s_dma_cmd_t       nxt_cmd;
  logic             go_rise;
  logic             hs;
  logic             err_set;
  logic             stop;
  logic             dec;
  logic [OUT_W-1:0] out_nxt;
  logic             out_full_nxt;

  assign go_rise = dma_go_i & ~go_q;
  assign hs      = cmd_valid_o & cmd_ready_i;
  assign err_set = cmp_valid_i & cmp_err_i;
  assign stop    = dma_error_o | err_set | abort_req | dma_abort_i;

  assign dec          = cmp_valid_i & (outst != '0);
  assign out_nxt      = outst + OUT_W'(hs) - OUT_W'(dec);
  assign out_full_nxt = (out_nxt == OUT_W'(MAX_OUTSTANDING));

  assign cand       = dma_desc_i[idx[IDX_W-1:0]];
  assign idx_end    = (idx == CNT_W'(DMA_NUM_DESC));
  assign cand_ok    = cand.enable && (cand.num_bytes != '0);
  assign cand_beats = ({1'b0, cand.num_bytes} + BW'(BYTES_PER_BEAT - 1)) >> SHIFT;

  // In LOAD the first burst is sized straight from the descriptor; later bursts use the running registers.
  assign is_load  = (state == ST_LOAD);
  assign calc_src = is_load ? (cand.src_addr & ALIGN_MASK) : cur_src;
  assign calc_dst = is_load ? (cand.dst_addr & ALIGN_MASK) : cur_dst;
  assign calc_rem = is_load ? cand_beats : beats_rem;
  assign calc_rdf = is_load ? cand.rd_mode : rd_fix;
  assign calc_wrf = is_load ? cand.wr_mode : wr_fix;

  dma_burst_calc #(
    .BYTES_PER_BEAT (BYTES_PER_BEAT)
  ) u_burst_calc (
    .src_off   (calc_src[11:0]),
    .dst_off   (calc_dst[11:0]),
    .beats_rem (calc_rem),
    .max_burst (dma_max_burst_i),
    .rd_fixed  (calc_rdf),
    .wr_fixed  (calc_wrf),
    .beats_c   (beats)
  );

  assign step    = AW'(beats) << SHIFT;
  assign nxt_src = calc_rdf ? calc_src : calc_src + step;
  assign nxt_dst = calc_wrf ? calc_dst : calc_dst + step;
  assign nxt_rem = calc_rem - BW'(beats);

  // Command payload for the burst about to be presented.
  always_comb begin
    nxt_cmd          = '0;
    nxt_cmd.src      = calc_src;
    nxt_cmd.dst      = calc_dst;
    nxt_cmd.alen     = 8'(beats - 9'd1);
    nxt_cmd.rd_fixed = calc_rdf;
    nxt_cmd.wr_fixed = calc_wrf;
    nxt_cmd.last     = (nxt_rem == '0);
  end

  assign cmd_src_o      = cmd_q.src;
  assign cmd_dst_o      = cmd_q.dst;
  assign cmd_alen_o     = cmd_q.alen;
  assign cmd_rd_fixed_o = cmd_q.rd_fixed;
  assign cmd_wr_fixed_o = cmd_q.wr_fixed;
  assign cmd_last_o     = cmd_q.last;

  // Scheduler FSM with registered command, status and outstanding counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      go_q         <= 1'b0;
      idx          <= '0;
      cur_src      <= '0;
      cur_dst      <= '0;
      beats_rem    <= '0;
      rd_fix       <= 1'b0;
      wr_fix       <= 1'b0;
      outst        <= '0;
      abort_req    <= 1'b0;
      cmd_q        <= '0;
      cmd_valid_o  <= 1'b0;
      dma_done_o   <= 1'b0;
      dma_error_o  <= 1'b0;
      dma_active_o <= 1'b0;
    end else begin
      go_q  <= dma_go_i;
      outst <= out_nxt;
      if (err_set) dma_error_o <= 1'b1;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (go_rise) begin
            state        <= ST_LOAD;
            idx          <= '0;
            outst        <= '0;
            abort_req    <= 1'b0;
            dma_done_o   <= 1'b0;
            dma_error_o  <= 1'b0;
            dma_active_o <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (dma_abort_i) abort_req <= 1'b1;
          if (stop || idx_end) begin
            state <= ST_DRAIN;
          end else if (cand_ok) begin
            cmd_q       <= nxt_cmd;
            cur_src     <= nxt_src;
            cur_dst     <= nxt_dst;
            beats_rem   <= nxt_rem;
            rd_fix      <= cand.rd_mode;
            wr_fix      <= cand.wr_mode;
            cmd_valid_o <= !out_full_nxt;
            state       <= ST_ISSUE;
          end else begin
            idx <= idx + CNT_W'(1);
          end
        end
        ST_ISSUE: begin
          if (dma_abort_i) abort_req <= 1'b1;
          if (cmd_valid_o && !hs) begin
            // A presented command survives an abort, but an error withdraws it before it is accepted.
            if (err_set) begin
              cmd_valid_o <= 1'b0;
              state       <= ST_DRAIN;
            end
          end else if (stop) begin
            cmd_valid_o <= 1'b0;
            state       <= ST_DRAIN;
          end else if (hs && cmd_q.last) begin
            cmd_valid_o <= 1'b0;
            idx         <= idx + CNT_W'(1);
            state       <= ST_LOAD;
          end else if (hs) begin
            cmd_q       <= nxt_cmd;
            cur_src     <= nxt_src;
            cur_dst     <= nxt_dst;
            beats_rem   <= nxt_rem;
            cmd_valid_o <= !out_full_nxt;
          end else begin
            cmd_valid_o <= !out_full_nxt;
          end
        end
        ST_DRAIN: begin
          cmd_valid_o <= 1'b0;
          if (out_nxt == '0) begin
            state        <= ST_DONE;
            dma_done_o   <= 1'b1;
            dma_active_o <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_desc_sched.sv
// Directed bench for dma_desc_sched: table of descriptor setups with expected bursts, plus corner sequences.
module tb_dma_desc_sched;
  import dma_utils_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic dma_go_i;
  logic dma_abort_i;
  logic [7:0] dma_max_burst_i;
  s_dma_desc_t desc [DMA_NUM_DESC];
  logic cmd_valid_o;
  logic cmd_ready_i;
  logic [DMA_ADDR_WIDTH-1:0] cmd_src_o;
  logic [DMA_ADDR_WIDTH-1:0] cmd_dst_o;
  logic [7:0] cmd_alen_o;
  logic cmd_rd_fixed_o;
  logic cmd_wr_fixed_o;
  logic cmd_last_o;
  logic cmp_valid_i;
  logic cmp_err_i;
  logic dma_done_o;
  logic dma_error_o;
  logic dma_active_o;

  always #5 clk = ~clk;

  dma_desc_sched #(.MAX_OUTSTANDING(4), .BYTES_PER_BEAT(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .dma_go_i        (dma_go_i),
    .dma_abort_i     (dma_abort_i),
    .dma_max_burst_i (dma_max_burst_i),
    .dma_desc_i      (desc),
    .cmd_valid_o     (cmd_valid_o),
    .cmd_ready_i     (cmd_ready_i),
    .cmd_src_o       (cmd_src_o),
    .cmd_dst_o       (cmd_dst_o),
    .cmd_alen_o      (cmd_alen_o),
    .cmd_rd_fixed_o  (cmd_rd_fixed_o),
    .cmd_wr_fixed_o  (cmd_wr_fixed_o),
    .cmd_last_o      (cmd_last_o),
    .cmp_valid_i     (cmp_valid_i),
    .cmp_err_i       (cmp_err_i),
    .dma_done_o      (dma_done_o),
    .dma_error_o     (dma_error_o),
    .dma_active_o    (dma_active_o)
  );

  typedef struct {
    s_dma_desc_t      d0;
    s_dma_desc_t      d1;
    logic [7:0]       max_burst;
    int               n_cmd;
    s_dma_cmd_t [3:0] exp;
  } vec_t;

  vec_t vecs [4];
  int n_vec = 0;
  int n_err = 0;
  int hs_count, cmp_owed, cmp_budget, cmp_given, err_idx, ready_limit;
  s_dma_cmd_t cap [$];

  function automatic s_dma_desc_t mk_desc(input logic [31:0] s, input logic [31:0] d,
                                          input logic [23:0] n, input logic rd, input logic wr,
                                          input logic en);
    s_dma_desc_t r;
    r.src_addr = s; r.dst_addr = d; r.num_bytes = n;
    r.rd_mode = rd; r.wr_mode = wr; r.enable = en;
    return r;
  endfunction

  function automatic s_dma_cmd_t mk_cmd(input logic [31:0] s, input logic [31:0] d,
                                        input logic [7:0] alen, input logic rdf,
                                        input logic wrf, input logic last);
    s_dma_cmd_t r;
    r.src = s; r.dst = d; r.alen = alen;
    r.rd_fixed = rdf; r.wr_fixed = wrf; r.last = last;
    return r;
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample outputs just after the edge, then drive completions and ready for this cycle.
  task automatic tick();
    s_dma_cmd_t c;
    @(posedge clk);
    #1;
    cmp_valid_i = 1'b0;
    cmp_err_i   = 1'b0;
    if (cmp_owed > 0 && cmp_budget > 0) begin
      cmp_valid_i = 1'b1;
      cmp_owed--;
      cmp_budget--;
      cmp_given++;
      cmp_err_i = (cmp_given == err_idx);
    end
    cmd_ready_i = (hs_count < ready_limit);
    if (cmd_valid_o && cmd_ready_i) begin
      c = mk_cmd(cmd_src_o, cmd_dst_o, cmd_alen_o, cmd_rd_fixed_o, cmd_wr_fixed_o, cmd_last_o);
      cap.push_back(c);
      hs_count++;
      cmp_owed++;
    end
  endtask

  task automatic start();
    dma_go_i = 1'b0;
    tick();
    cap.delete();
    hs_count  = 0;
    cmp_given = 0;
    cmp_owed  = 0;
    dma_go_i  = 1'b1;
  endtask

  task automatic run_to_done(input int budget);
    for (int n = 0; n < budget; n++) begin
      tick();
      if (dma_done_o) break;
    end
  endtask

  initial begin
    int first;
    s_dma_cmd_t act;

    vecs[0].d0 = mk_desc(32'h1000, 32'h2000, 24'd64, 1'b0, 1'b0, 1'b1);
    vecs[0].d1 = mk_desc(32'h0, 32'h0, 24'd0, 1'b0, 1'b0, 1'b0);
    vecs[0].max_burst = 8'd3;
    vecs[0].n_cmd = 4;
    vecs[0].exp[0] = mk_cmd(32'h1000, 32'h2000, 8'd3, 1'b0, 1'b0, 1'b0);
    vecs[0].exp[1] = mk_cmd(32'h1010, 32'h2010, 8'd3, 1'b0, 1'b0, 1'b0);
    vecs[0].exp[2] = mk_cmd(32'h1020, 32'h2020, 8'd3, 1'b0, 1'b0, 1'b0);
    vecs[0].exp[3] = mk_cmd(32'h1030, 32'h2030, 8'd3, 1'b0, 1'b0, 1'b1);

    vecs[1].d0 = mk_desc(32'h0FF8, 32'h3000, 24'd32, 1'b0, 1'b0, 1'b1);
    vecs[1].d1 = mk_desc(32'h0, 32'h0, 24'd0, 1'b0, 1'b0, 1'b0);
    vecs[1].max_burst = 8'd15;
    vecs[1].n_cmd = 2;
    vecs[1].exp[0] = mk_cmd(32'h0FF8, 32'h3000, 8'd1, 1'b0, 1'b0, 1'b0);
    vecs[1].exp[1] = mk_cmd(32'h1000, 32'h3008, 8'd5, 1'b0, 1'b0, 1'b1);
    vecs[1].exp[2] = '0;
    vecs[1].exp[3] = '0;

    vecs[2].d0 = mk_desc(32'h7000, 32'h7100, 24'd16, 1'b0, 1'b0, 1'b0);
    vecs[2].d1 = mk_desc(32'h5000, 32'h4000, 24'd12, 1'b0, 1'b1, 1'b1);
    vecs[2].max_burst = 8'd15;
    vecs[2].n_cmd = 1;
    vecs[2].exp[0] = mk_cmd(32'h5000, 32'h4000, 8'd2, 1'b0, 1'b1, 1'b1);
    vecs[2].exp[1] = '0;
    vecs[2].exp[2] = '0;
    vecs[2].exp[3] = '0;

    // Fixed source caps at 16 beats; unaligned addresses and odd byte counts round to whole beats.
    vecs[3].d0 = mk_desc(32'h0102, 32'h0000, 24'd100, 1'b1, 1'b0, 1'b1);
    vecs[3].d1 = mk_desc(32'h8000, 32'h9006, 24'd7, 1'b0, 1'b0, 1'b1);
    vecs[3].max_burst = 8'd255;
    vecs[3].n_cmd = 3;
    vecs[3].exp[0] = mk_cmd(32'h0100, 32'h0000, 8'd15, 1'b1, 1'b0, 1'b0);
    vecs[3].exp[1] = mk_cmd(32'h0100, 32'h0040, 8'd8, 1'b1, 1'b0, 1'b1);
    vecs[3].exp[2] = mk_cmd(32'h8000, 32'h9004, 8'd1, 1'b0, 1'b0, 1'b1);
    vecs[3].exp[3] = '0;

    rst_n = 1'b0;
    dma_go_i = 1'b0;
    dma_abort_i = 1'b0;
    dma_max_burst_i = 8'd0;
    cmd_ready_i = 1'b0;
    cmp_valid_i = 1'b0;
    cmp_err_i = 1'b0;
    for (int i = 0; i < DMA_NUM_DESC; i++) desc[i] = '0;
    hs_count = 0; cmp_owed = 0; cmp_budget = 0; cmp_given = 0; err_idx = 0; ready_limit = 0;

    repeat (3) tick();
    check("rst_valid", 96'(cmd_valid_o), 96'(0));
    check("rst_status", 96'({dma_done_o, dma_error_o, dma_active_o}), 96'(0));
    check("rst_cmd", 96'({cmd_src_o, cmd_dst_o, cmd_alen_o, cmd_last_o}), 96'(0));
    rst_n = 1'b1;
    repeat (2) tick();
    check("idle_valid", 96'(cmd_valid_o), 96'(0));

    // Table-driven transfers with ready=1 and completions one cycle after each handshake.
    for (int v = 0; v < 4; v++) begin
      desc[0] = vecs[v].d0;
      desc[1] = vecs[v].d1;
      dma_max_burst_i = vecs[v].max_burst;
      ready_limit = 1000;
      cmp_budget = 1000000;
      err_idx = 0;
      start();
      first = 0;
      for (int n = 1; n <= 400; n++) begin
        tick();
        if (first == 0 && cmd_valid_o) begin
          first = n;
          check($sformatf("v%0d_active", v), 96'(dma_active_o), 96'(1));
        end
        if (dma_done_o) break;
      end
      check($sformatf("v%0d_latency", v), 96'(first), 96'(vecs[v].d0.enable ? 2 : 3));
      check($sformatf("v%0d_ncmd", v), 96'(cap.size()), 96'(vecs[v].n_cmd));
      for (int i = 0; i < vecs[v].n_cmd; i++) begin
        act = (i < cap.size()) ? cap[i] : '0;
        check($sformatf("v%0d_cmd%0d", v, i), 96'(act), 96'(vecs[v].exp[i]));
      end
      check($sformatf("v%0d_done_err_act", v), 96'({dma_done_o, dma_error_o, dma_active_o}),
            96'(3'b100));
    end

    // Outstanding limit: 8 bursts, completions withheld.
    desc[0] = mk_desc(32'h0000, 32'h10000, 24'd128, 1'b0, 1'b0, 1'b1);
    desc[1] = '0;
    dma_max_burst_i = 8'd3;
    ready_limit = 1000;
    cmp_budget = 0;
    start();
    repeat (30) tick();
    check("outst_hs4", 96'(hs_count), 96'(4));
    check("outst_valid_low", 96'(cmd_valid_o), 96'(0));
    cmp_budget = 1;
    repeat (10) tick();
    check("outst_hs5", 96'(hs_count), 96'(5));
    check("outst_valid_low2", 96'(cmd_valid_o), 96'(0));
    cmp_budget = 1000000;
    run_to_done(200);
    check("outst_hs8", 96'(hs_count), 96'(8));
    act = (cap.size() == 8) ? cap[7] : '0;
    check("outst_last_cmd", 96'(act), 96'(mk_cmd(32'h0070, 32'h10070, 8'd3, 1'b0, 1'b0, 1'b1)));
    check("outst_done", 96'({dma_done_o, dma_error_o}), 96'(2'b10));

    // Abort while a command is stalled: it is held, then accepted, then nothing more.
    desc[0] = mk_desc(32'h1000, 32'h2000, 24'd64, 1'b0, 1'b0, 1'b1);
    ready_limit = 1;
    start();
    repeat (6) tick();
    dma_abort_i = 1'b1;
    repeat (4) tick();
    check("abort_held_valid", 96'(cmd_valid_o), 96'(1));
    check("abort_held_src", 96'(cmd_src_o), 96'(32'h1010));
    check("abort_hs1", 96'(hs_count), 96'(1));
    ready_limit = 1000;
    run_to_done(100);
    check("abort_hs2", 96'(hs_count), 96'(2));
    check("abort_done", 96'({dma_done_o, dma_error_o}), 96'(2'b10));
    dma_abort_i = 1'b0;

    // Error on the 2nd completion while the 3rd command is stalled.
    ready_limit = 2;
    err_idx = 2;
    start();
    run_to_done(100);
    check("err_hs2", 96'(hs_count), 96'(2));
    check("err_done", 96'({dma_done_o, dma_error_o}), 96'(2'b11));
    ready_limit = 1000;
    repeat (5) tick();
    check("err_no_more", 96'({hs_count[3:0], cmd_valid_o}), 96'({4'd2, 1'b0}));

    // A new go clears done and error and runs normally.
    err_idx = 0;
    start();
    tick();
    check("restart_clear", 96'({dma_done_o, dma_error_o, dma_active_o}), 96'(3'b001));
    run_to_done(200);
    check("restart_hs", 96'(hs_count), 96'(4));
    check("restart_done", 96'({dma_done_o, dma_error_o}), 96'(2'b10));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
